// File: rtl/iter_comparator.sv
// rtl/iter_comparator.sv - multi-cycle chunked magnitude comparator
// Compares from the MSB chunk down and stops at the first differing chunk.
module iter_comparator #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       op_i,
  input  logic             is_signed_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             result_o,
  output logic             eq_o,
  output logic             gt_o,
  output logic             lt_o
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0]  IDX_TOP  = IDXW'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q;
  logic [WIDTH-1:0]  a_q, b_q;
  logic [2:0]        op_q;
  logic [IDXW-1:0]   idx_q;
  logic              result_q, eq_q, gt_q, lt_q;

  logic [CHUNK-1:0]  chunk_a, chunk_b;
  logic              eq_d, gt_d, lt_d, result_d;

  // Operands are shifted left each BUSY cycle, so the live chunk is always at the top.
  assign chunk_a = a_q[WIDTH-1 -: CHUNK];
  assign chunk_b = b_q[WIDTH-1 -: CHUNK];

  always_comb begin
    eq_d     = (chunk_a == chunk_b);
    gt_d     = (chunk_a >  chunk_b);
    lt_d     = (chunk_a <  chunk_b);
    result_d = 1'b0;
    case (op_q)
      3'b000:  result_d = eq_d;
      3'b001:  result_d = gt_d;
      3'b010:  result_d = lt_d;
      3'b011:  result_d = gt_d | eq_d;
      3'b100:  result_d = lt_d | eq_d;
      3'b101:  result_d = ~eq_d;
      default: result_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      idx_q    <= IDX_TOP;
      result_q <= 1'b0;
      eq_q     <= 1'b0;
      gt_q     <= 1'b0;
      lt_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            // Flipping the sign bit maps two's-complement order onto unsigned order.
            a_q     <= a_i ^ (is_signed_i ? MSB_MASK : '0);
            b_q     <= b_i ^ (is_signed_i ? MSB_MASK : '0);
            op_q    <= op_i;
            idx_q   <= IDX_TOP;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (!eq_d || idx_q == '0) begin
            eq_q     <= eq_d;
            gt_q     <= gt_d;
            lt_q     <= lt_d;
            result_q <= result_d;
            state_q  <= DONE;
          end else begin
            a_q   <= a_q << CHUNK;
            b_q   <= b_q << CHUNK;
            idx_q <= idx_q - 1'b1;
          end
        end
        DONE: begin
          if (out_ready_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign result_o    = result_q;
  assign eq_o        = eq_q;
  assign gt_o        = gt_q;
  assign lt_o        = lt_q;

endmodule

// File: tb/tb_iter_comparator.sv
// tb/tb_iter_comparator.sv - directed bench for iter_comparator
module tb_iter_comparator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b;
  logic [2:0]  op;
  logic        is_signed;
  logic        result, eq, gt, lt;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [2:0] OP_EQ = 3'd0, OP_GT = 3'd1, OP_LT = 3'd2,
                         OP_GE = 3'd3, OP_LE = 3'd4, OP_NE = 3'd5, OP_RSV = 3'd6;

  always #5 clk = ~clk;

  iter_comparator #(.WIDTH(32), .CHUNK(8)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .a_i         (a),
    .b_i         (b),
    .op_i        (op),
    .is_signed_i (is_signed),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .result_o    (result),
    .eq_o        (eq),
    .gt_o        (gt),
    .lt_o        (lt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [31:0] av, input logic [31:0] bv,
                       input logic [2:0] opv, input logic sv);
    a = av; b = bv; op = opv; is_signed = sv;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic ack(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ".ack_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, ".ack_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  // flags packed as {eq, gt, lt}
  task automatic run(input string tag, input logic [31:0] av, input logic [31:0] bv,
                     input logic [2:0] opv, input logic sv, input logic exp_res,
                     input logic [2:0] exp_flags, input int exp_lat);
    int lat;
    check({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    issue(av, bv, opv, sv);
    wait_done(lat);
    check({tag, ".latency"}, lat, exp_lat);
    check({tag, ".result"}, {31'd0, result}, {31'd0, exp_res});
    check({tag, ".flags"}, {29'd0, eq, gt, lt}, {29'd0, exp_flags});
    ack(tag);
  endtask

  initial begin
    logic seen;
    int   lat;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; op = '0; is_signed = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.in_ready", {31'd0, in_ready}, 32'd1);
    check("rst.out_valid", {31'd0, out_valid}, 32'd0);
    check("rst.outs", {28'd0, result, eq, gt, lt}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run("s_lt_min",   32'h8000_0000, 32'h0000_0001, OP_LT,  1'b1, 1'b1, 3'b001, 1);
    run("u_gt_min",   32'h8000_0000, 32'h0000_0001, OP_GT,  1'b0, 1'b1, 3'b010, 1);
    run("eq_eq",      32'h1234_5678, 32'h1234_5678, OP_EQ,  1'b0, 1'b1, 3'b100, 4);
    run("eq_ne",      32'h1234_5678, 32'h1234_5678, OP_NE,  1'b0, 1'b0, 3'b100, 4);
    run("s_ge",       32'h1234_5679, 32'h1234_5678, OP_GE,  1'b1, 1'b1, 3'b010, 4);
    run("s_le",       32'h1234_5679, 32'h1234_5678, OP_LE,  1'b1, 1'b0, 3'b010, 4);
    run("s_neg1_lt",  32'hFFFF_FFFF, 32'h0000_0000, OP_LT,  1'b1, 1'b1, 3'b001, 1);
    run("u_gt_lat2",  32'h0001_0000, 32'h0002_0000, OP_GT,  1'b0, 1'b0, 3'b001, 2);
    run("reserved",   32'h0000_0001, 32'h0000_0002, OP_RSV, 1'b0, 1'b0, 3'b001, 4);
    run("u_ge_eq",    32'hCAFE_0000, 32'hCAFE_0000, OP_GE,  1'b0, 1'b1, 3'b100, 4);

    // Backpressure: held DONE must ignore a new command.
    issue(32'h8000_0000, 32'h0000_0001, OP_LT, 1'b1);
    wait_done(lat);
    check("bp.latency", lat, 1);
    for (int i = 0; i < 5; i++) begin
      a = 32'h0000_0005; b = 32'h0000_0005; op = OP_EQ; is_signed = 1'b0;
      in_valid = 1'b1;
      @(posedge clk); #1;
      check($sformatf("bp.hold%0d", i), {27'd0, out_valid, in_ready, result, eq, gt, lt},
            {27'd0, 1'b1, 1'b0, 1'b1, 3'b001});
    end
    in_valid = 1'b0;
    ack("bp");
    seen = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      seen |= out_valid;
    end
    check("bp.not_latched", {31'd0, seen}, 32'd0);

    // Reset while BUSY aborts the command.
    issue(32'h0000_0001, 32'h0000_0002, OP_LT, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort.in_ready", {31'd0, in_ready}, 32'd1);
    check("abort.outs", {27'd0, out_valid, result, eq, gt, lt}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      seen |= out_valid;
    end
    check("abort.no_valid", {31'd0, seen}, 32'd0);
    run("post_abort", 32'h0000_0001, 32'h0000_0002, OP_LT, 1'b0, 1'b1, 3'b001, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
